// File: rtl/acc_requant_if.sv
// acc_requant_if: row stream interface of the requantisation stage.
//   in_valid / in_ready / in_data   : one row of DP signed DW-bit partial sums
//   out_valid / out_ready / out_data: one row of DP OW-bit activations
//   out_last_row / out_last_ch      : position flags travelling with out_data
// Modports: slave = the stage itself, master = producer/consumer side.
interface acc_requant_if #(
  parameter int DW = 32,
  parameter int DP = 56,
  parameter int OW = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DW*DP-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [OW*DP-1:0]  out_data;
  logic              out_last_row;
  logic              out_last_ch;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last_row, out_last_ch
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last_row, out_last_ch
  );
endinterface

// File: rtl/acc_requant.sv
// acc_requant: adds the per-channel bias to each row of merged partial sums,
// optionally applies ReLU, then rounds, right-shifts and saturates every lane
// to an OW-bit activation. Row/channel position is tracked internally and
// selects the bias/shift table entry.
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   start            frame start: clears counters and drops in-flight rows
//   relu_en          1: ReLU + unsigned saturate, 0: signed saturate
//   cfg_we/addr/bias/shift  bias/shift table write port (indexed by channel)
//   bus (slave)      input row stream and output activation stream
// Two register stages: S1 holds the row plus its table entry, S2 holds the
// finished activations.
module acc_requant #(
  parameter int DW   = 32,
  parameter int DP   = 56,
  parameter int OW   = 8,
  parameter int ROWS = 56,
  parameter int CH   = 64,
  parameter int SHW  = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    relu_en,
  input  logic                    cfg_we,
  input  logic [$clog2(CH)-1:0]   cfg_addr,
  input  logic signed [DW-1:0]    cfg_bias,
  input  logic [SHW-1:0]          cfg_shift,
  acc_requant_if.slave            bus
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(CH);
  // DW+1 bits hold x+bias exactly; one more bit keeps the rounding add from wrapping.
  localparam int SW = DW + 2;
  localparam logic signed [SW-1:0] U_MAX = SW'((1 << OW) - 1);
  localparam logic signed [SW-1:0] S_MAX = SW'((1 << (OW - 1)) - 1);
  localparam logic signed [SW-1:0] S_MIN = ~S_MAX;

  logic signed [DW-1:0] bias_mem [CH];
  logic [SHW-1:0]       shift_mem [CH];

  logic en1, en2, in_ready, accept;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic [CW-1:0] ch_cnt_q, ch_cnt_d;
  logic v1_q, v1_d, v2_q, v2_d;
  logic [DW*DP-1:0] x1_q, x1_d;
  logic relu1_q, relu1_d, last_row1_q, last_row1_d, last_ch1_q, last_ch1_d;
  logic signed [DW-1:0] bias1_q;
  logic [SHW-1:0] shift1_q;
  logic [OW*DP-1:0] out_data_q, out_data_d, lane_out;
  logic out_last_row_q, out_last_row_d, out_last_ch_q, out_last_ch_d;
  logic signed [SW-1:0] rnd;

  // in_ready depends on pipeline occupancy and out_ready only, never on in_valid.
  always_comb begin
    en2      = !v2_q || bus.out_ready;
    en1      = !v1_q || en2;
    in_ready = en1 && !start;
    accept   = bus.in_valid && in_ready;
  end

  always_comb begin
    row_cnt_d      = row_cnt_q;
    ch_cnt_d       = ch_cnt_q;
    v1_d           = v1_q;
    v2_d           = v2_q;
    x1_d           = x1_q;
    relu1_d        = relu1_q;
    last_row1_d    = last_row1_q;
    last_ch1_d     = last_ch1_q;
    out_data_d     = out_data_q;
    out_last_row_d = out_last_row_q;
    out_last_ch_d  = out_last_ch_q;
    if (start) begin
      row_cnt_d = '0;
      ch_cnt_d  = '0;
      v1_d      = 1'b0;
      v2_d      = 1'b0;
    end else begin
      if (accept) begin
        x1_d        = bus.in_data;
        relu1_d     = relu_en;
        last_row1_d = (row_cnt_q == RW'(ROWS - 1));
        last_ch1_d  = (ch_cnt_q == CW'(CH - 1));
        if (row_cnt_q == RW'(ROWS - 1)) begin
          row_cnt_d = '0;
          ch_cnt_d  = (ch_cnt_q == CW'(CH - 1)) ? '0 : ch_cnt_q + 1'b1;
        end else begin
          row_cnt_d = row_cnt_q + 1'b1;
        end
      end
      if (en1) v1_d = accept;
      if (en2) begin
        v2_d = v1_q;
        if (v1_q) begin
          out_data_d     = lane_out;
          out_last_row_d = last_row1_q;
          out_last_ch_d  = last_ch1_q;
        end
      end
    end
  end

  // Table write and registered table read share one edge, so a row accepted
  // on the write edge still sees the previous entry.
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      bias_mem[cfg_addr]  <= cfg_bias;
      shift_mem[cfg_addr] <= cfg_shift;
    end
    if (accept) begin
      bias1_q  <= bias_mem[ch_cnt_q];
      shift1_q <= shift_mem[ch_cnt_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt_q      <= '0;
      ch_cnt_q       <= '0;
      v1_q           <= 1'b0;
      v2_q           <= 1'b0;
      x1_q           <= '0;
      relu1_q        <= 1'b0;
      last_row1_q    <= 1'b0;
      last_ch1_q     <= 1'b0;
      out_data_q     <= '0;
      out_last_row_q <= 1'b0;
      out_last_ch_q  <= 1'b0;
    end else begin
      row_cnt_q      <= row_cnt_d;
      ch_cnt_q       <= ch_cnt_d;
      v1_q           <= v1_d;
      v2_q           <= v2_d;
      x1_q           <= x1_d;
      relu1_q        <= relu1_d;
      last_row1_q    <= last_row1_d;
      last_ch1_q     <= last_ch1_d;
      out_data_q     <= out_data_d;
      out_last_row_q <= out_last_row_d;
      out_last_ch_q  <= out_last_ch_d;
    end
  end

  // Half-LSB rounding constant, shared by all lanes of the row.
  always_comb begin
    rnd = '0;
    if (shift1_q != '0) rnd = SW'(1) <<< (shift1_q - SHW'(1));
  end

  for (genvar gi = 0; gi < DP; gi++) begin : g_lane
    logic signed [SW-1:0] s, r, sat;
    always_comb begin
      s = SW'(signed'(x1_q[DW*gi +: DW])) + SW'(bias1_q);
      r = (s + rnd) >>> shift1_q;
      if (relu1_q) begin
        if (r[SW-1])       sat = '0;
        else if (r > U_MAX) sat = U_MAX;
        else               sat = r;
      end else begin
        if (r > S_MAX)      sat = S_MAX;
        else if (r < S_MIN) sat = S_MIN;
        else               sat = r;
      end
    end
    assign lane_out[OW*gi +: OW] = OW'(sat);
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = v2_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_last_row = out_last_row_q;
  assign bus.out_last_ch  = out_last_ch_q;
endmodule
